// File: rtl/sync_sram_fifo_pkg.sv
// Shared sizing helpers for the SRAM-backed synchronous FIFO.
// Depth and pointer/count widths are derived from the address width in one place.
package sync_sram_fifo_pkg;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    // One extra bit beyond the address distinguishes full from empty.
    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/sync_sram_fifo_ram.sv
// Single-write, single-read SRAM array with a read-first registered read port.
// Storage is never reset; only the output register is cleared.
module sync_ram
    import sync_sram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] w_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] r_addr,
    output logic [DATA_WIDTH-1:0] r_data
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[w_addr] <= w_data;
        end
    end

    // Non-blocking update makes a same-address read return the pre-write word.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= '0;
        end else if (re) begin
            r_data <= mem[r_addr];
        end
    end

endmodule

// File: rtl/sync_sram_fifo.sv
// Synchronous FIFO over a registered-read SRAM: pointers, occupancy, flags
// and overflow/underflow pulses. Flags decode registered state only.
module sync_sram_fifo
    import sync_sram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_LEVEL   = fifo_depth(ADDR_WIDTH) - 2,
    parameter int AE_LEVEL   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  r_valid,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int               PTR_W     = ptr_width(ADDR_WIDTH);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W-1:0] AF_THRESH = PTR_W'(AF_LEVEL);
    localparam logic [PTR_W-1:0] AE_THRESH = PTR_W'(AE_LEVEL);

    logic [PTR_W-1:0] w_ptr;
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] count_q;
    logic             do_wr;
    logic             do_rd;

    assign empty = (w_ptr == r_ptr);
    assign full  = (w_ptr[ADDR_WIDTH] != r_ptr[ADDR_WIDTH]) &&
                   (w_ptr[ADDR_WIDTH-1:0] == r_ptr[ADDR_WIDTH-1:0]);

    assign almost_empty = (count_q <= AE_THRESH);
    assign almost_full  = (count_q >= AF_THRESH);
    assign count        = count_q;

    // A pop frees a slot in the same cycle, so a full FIFO still takes a push alongside it.
    assign do_wr = wr & (~full | rd) & ~reset;
    assign do_rd = rd & ~empty & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            w_ptr     <= '0;
            r_ptr     <= '0;
            count_q   <= '0;
            r_valid   <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (do_wr) begin
                w_ptr <= w_ptr + PTR_ONE;
            end
            if (do_rd) begin
                r_ptr <= r_ptr + PTR_ONE;
            end
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + PTR_ONE;
                2'b01:   count_q <= count_q - PTR_ONE;
                default: count_q <= count_q;
            endcase
            r_valid   <= do_rd;
            overflow  <= wr & full & ~rd;
            // A pop against an empty FIFO with a concurrent push is not an error.
            underflow <= rd & empty & ~wr;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (count_q == PTR_W'(w_ptr - r_ptr));
        end
    end

    sync_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk    (clk),
        .reset  (reset),
        .we     (do_wr),
        .w_addr (w_ptr[ADDR_WIDTH-1:0]),
        .w_data (w_data),
        .re     (do_rd),
        .r_addr (r_ptr[ADDR_WIDTH-1:0]),
        .r_data (r_data)
    );

endmodule

// File: tb/tb_sync_sram_fifo.sv
// Bench for sync_sram_fifo: queue-based reference model and a read scoreboard,
// plus scenario tasks with their own targeted checks.
module tb_sync_sram_fifo;

    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr;
    logic          rd;
    logic [DW-1:0] w_data;
    logic [DW-1:0] r_data;
    logic          r_valid;
    logic          empty;
    logic          full;
    logic          almost_empty;
    logic          almost_full;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] m_q[$];
    logic [DW-1:0] exp_q[$];
    logic          exp_ovf;
    logic          exp_udf;
    logic          exp_valid;

    always #5 clk = ~clk;

    sync_sram_fifo #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .AF_LEVEL   (3),
        .AE_LEVEL   (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr           (wr),
        .w_data       (w_data),
        .rd           (rd),
        .r_data       (r_data),
        .r_valid      (r_valid),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    // One clock of stimulus: update the model, then compare the DUT after the edge.
    task automatic drive_cycle(input logic rst, input logic w, input logic [DW-1:0] d, input logic r);
        logic m_empty;
        logic m_full;
        logic [DW-1:0] exp_d;
        reset  = rst;
        wr     = w;
        w_data = d;
        rd     = r;
        if (rst) begin
            m_q.delete();
            exp_q.delete();
            exp_ovf   = 1'b0;
            exp_udf   = 1'b0;
            exp_valid = 1'b0;
        end else begin
            m_empty   = (m_q.size() == 0);
            m_full    = (m_q.size() == DEPTH);
            exp_ovf   = w && m_full && !r;
            exp_udf   = r && m_empty && !w;
            exp_valid = r && !m_empty;
            if (exp_valid) exp_q.push_back(m_q.pop_front());
            if (w && (!m_full || r)) m_q.push_back(d);
        end
        @(posedge clk);
        #1;
        total++;
        if (r_valid !== exp_valid) begin
            bad++;
            $display("FAIL r_valid: got %b want %b", r_valid, exp_valid);
        end
        if (r_valid === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_underrun: got data %h want no word", r_data);
            end else begin
                exp_d = exp_q.pop_front();
                if (r_data !== exp_d) begin
                    bad++;
                    $display("FAIL sb_data: got %h want %h", r_data, exp_d);
                end
            end
        end
        total++;
        if (count !== 3'(m_q.size())) begin
            bad++;
            $display("FAIL count: got %0d want %0d", count, m_q.size());
        end
        total++;
        if ({empty, full, almost_empty, almost_full} !==
            {m_q.size() == 0, m_q.size() == DEPTH, m_q.size() <= 1, m_q.size() >= 3}) begin
            bad++;
            $display("FAIL flags(e,f,ae,af): got %b%b%b%b want %b%b%b%b",
                     empty, full, almost_empty, almost_full,
                     m_q.size() == 0, m_q.size() == DEPTH, m_q.size() <= 1, m_q.size() >= 3);
        end
        total++;
        if ({overflow, underflow} !== {exp_ovf, exp_udf}) begin
            bad++;
            $display("FAIL ovf/udf: got %b%b want %b%b", overflow, underflow, exp_ovf, exp_udf);
        end
    endtask

    task automatic test_reset();
        drive_cycle(1'b1, 1'b0, 8'h00, 1'b0);
        drive_cycle(1'b1, 1'b0, 8'h00, 1'b0);
        drive_cycle(1'b0, 1'b0, 8'h00, 1'b0);
        total++;
        if ({empty, almost_empty, full, almost_full, r_valid} !== 5'b11000) begin
            bad++;
            $display("FAIL reset_flags: got %b%b%b%b%b want 11000", empty, almost_empty, full, almost_full, r_valid);
        end
        total++;
        if (count !== 3'd0 || r_data !== 8'h00) begin
            bad++;
            $display("FAIL reset_count_data: got %0d/%h want 0/00", count, r_data);
        end
    endtask

    task automatic test_fill();
        logic [DW-1:0] vals [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0, 1'b1, vals[i], 1'b0);
            total++;
            if (count !== 3'(i + 1) || almost_full !== (i >= 2) || full !== (i == 3)) begin
                bad++;
                $display("FAIL fill_step%0d: got cnt=%0d af=%b f=%b want cnt=%0d af=%b f=%b",
                         i, count, almost_full, full, i + 1, i >= 2, i == 3);
            end
        end
        drive_cycle(1'b0, 1'b1, 8'hEE, 1'b0);
        total++;
        if (overflow !== 1'b1 || count !== 3'd4) begin
            bad++;
            $display("FAIL overflow_push: got ovf=%b cnt=%0d want ovf=1 cnt=4", overflow, count);
        end
        drive_cycle(1'b0, 1'b0, 8'h00, 1'b0);
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL overflow_pulse: got %b want 0", overflow);
        end
    endtask

    task automatic test_drain();
        logic [DW-1:0] vals [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0, 1'b0, 8'h00, 1'b1);
            total++;
            if (r_valid !== 1'b1 || r_data !== vals[i]) begin
                bad++;
                $display("FAIL drain%0d: got v=%b d=%h want v=1 d=%h", i, r_valid, r_data, vals[i]);
            end
        end
        drive_cycle(1'b0, 1'b0, 8'h00, 1'b1);
        total++;
        if (underflow !== 1'b1 || empty !== 1'b1 || r_valid !== 1'b0 || r_data !== 8'hD4) begin
            bad++;
            $display("FAIL underflow_pop: got udf=%b e=%b v=%b d=%h want 1 1 0 d4", underflow, empty, r_valid, r_data);
        end
        drive_cycle(1'b0, 1'b0, 8'h00, 1'b0);
        total++;
        if (underflow !== 1'b0) begin
            bad++;
            $display("FAIL underflow_pulse: got %b want 0", underflow);
        end
    endtask

    task automatic test_simul_full();
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b1, 8'(8'h10 * (i + 1)), 1'b0);
        drive_cycle(1'b0, 1'b1, 8'h55, 1'b1);
        total++;
        if (r_data !== 8'h10 || count !== 3'd4 || overflow !== 1'b0 || full !== 1'b1) begin
            bad++;
            $display("FAIL simul_full: got d=%h cnt=%0d ovf=%b f=%b want 10 4 0 1", r_data, count, overflow, full);
        end
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b0, 8'h00, 1'b1);
        total++;
        if (r_data !== 8'h55 || empty !== 1'b1) begin
            bad++;
            $display("FAIL simul_full_tail: got d=%h e=%b want 55 1", r_data, empty);
        end
    endtask

    task automatic test_simul_empty();
        drive_cycle(1'b0, 1'b1, 8'h77, 1'b1);
        total++;
        if (count !== 3'd1 || r_valid !== 1'b0 || underflow !== 1'b0) begin
            bad++;
            $display("FAIL simul_empty: got cnt=%0d v=%b udf=%b want 1 0 0", count, r_valid, underflow);
        end
        drive_cycle(1'b0, 1'b0, 8'h00, 1'b1);
        total++;
        if (r_valid !== 1'b1 || r_data !== 8'h77) begin
            bad++;
            $display("FAIL simul_empty_pop: got v=%b d=%h want 1 77", r_valid, r_data);
        end
    endtask

    task automatic test_wrap_reset();
        for (int i = 1; i <= 3; i++) drive_cycle(1'b0, 1'b1, 8'(i), 1'b0);
        drive_cycle(1'b0, 1'b0, 8'h00, 1'b1);
        drive_cycle(1'b0, 1'b0, 8'h00, 1'b1);
        total++;
        if (r_data !== 8'h02) begin
            bad++;
            $display("FAIL wrap_order: got %h want 02", r_data);
        end
        for (int i = 4; i <= 7; i++) drive_cycle(1'b0, 1'b1, 8'(i), 1'b0);
        total++;
        if (overflow !== 1'b1 || full !== 1'b1) begin
            bad++;
            $display("FAIL wrap_full: got ovf=%b f=%b want 1 1", overflow, full);
        end
        drive_cycle(1'b0, 1'b0, 8'h00, 1'b1);
        total++;
        if (r_data !== 8'h03) begin
            bad++;
            $display("FAIL wrap_pop: got %h want 03", r_data);
        end
        drive_cycle(1'b1, 1'b1, 8'h99, 1'b0);
        drive_cycle(1'b0, 1'b0, 8'h00, 1'b0);
        total++;
        if ({empty, almost_empty, full, almost_full, r_valid, overflow, underflow} !== 7'b1100000 ||
            count !== 3'd0 || r_data !== 8'h00) begin
            bad++;
            $display("FAIL mid_reset: got e=%b ae=%b f=%b af=%b v=%b cnt=%0d d=%h want 1 1 0 0 0 0 00",
                     empty, almost_empty, full, almost_full, r_valid, count, r_data);
        end
        drive_cycle(1'b0, 1'b0, 8'h00, 1'b1);
        total++;
        if (underflow !== 1'b1 || r_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_write_dropped: got udf=%b v=%b want 1 0", underflow, r_valid);
        end
    endtask

    initial begin
        reset  = 1'b1;
        wr     = 1'b0;
        rd     = 1'b0;
        w_data = '0;
        test_reset();
        test_fill();
        test_drain();
        test_simul_full();
        test_simul_empty();
        test_wrap_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
